// File: rtl/bcd_digit_streamer.sv
// Purpose: NUM_DIGITS-digit BCD up/down counter that snapshots its value on request and streams it MSD first.
// Latency: first digit valid 1 cycle after start; NUM_DIGITS cycles per frame at full rate, plus 1 DONE cycle.
// Backpressure: each digit is held stable while out_valid=1 and out_ready=0; start is ignored while busy.
module bcd_digit_streamer #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    load_err,
    output logic                    busy,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_a,
    output logic                    out_b,
    output logic                    out_c,
    output logic                    out_d,
    output logic                    frame_done
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     snap;
    logic [W-1:0]     snap_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;

    logic [W-1:0]     cnt_up;
    logic [W-1:0]     cnt_dn;
    logic [W-1:0]     load_clean;
    logic             carry;
    logic             borrow;
    logic             load_bad;
    logic [3:0]       dig;
    logic [3:0]       cur_dig;

    // Ripple BCD increment/decrement candidates and a sanitised load value.
    // After the loop, carry/borrow are set only when every digit was 9 (resp. 0),
    // which is exactly the wrap condition.
    always_comb begin
        cnt_up     = '0;
        cnt_dn     = '0;
        load_clean = '0;
        carry      = 1'b1;
        borrow     = 1'b1;
        load_bad   = 1'b0;
        dig        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
                cnt_up[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
                cnt_up[4*i +: 4] = dig;
            end
            carry = carry & (dig == 4'd9);
            if (borrow) begin
                cnt_dn[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end else begin
                cnt_dn[4*i +: 4] = dig;
            end
            borrow = borrow & (dig == 4'd0);
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Counter register: load beats count enable; tc and load_err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                count    <= load_clean;
                load_err <= load_bad;
            end else if (en) begin
                if (up_dn) begin
                    count <= cnt_up;
                    tc    <= carry;
                end else begin
                    count <= cnt_dn;
                    tc    <= borrow;
                end
            end
        end
    end

    // Stream FSM state and frame registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            snap      <= snap_nxt;
            out_idx   <= idx_nxt;
            out_valid <= valid_nxt;
        end
    end

    // Next-state logic: snapshot on start from IDLE, step down the digit index on each handshake.
    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        idx_nxt   = out_idx;
        valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    snap_nxt  = count;
                    idx_nxt   = IDX_W'(NUM_DIGITS - 1);
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_idx != '0) begin
                        idx_nxt = out_idx - IDX_W'(1);
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select the snapshot digit under out_idx; forced to 0 when no digit is valid.
    always_comb begin
        cur_dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (out_valid && (out_idx == IDX_W'(i))) begin
                cur_dig = snap[4*i +: 4];
            end
        end
    end

    assign {out_a, out_b, out_c, out_d} = cur_dig;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Self-checking bench for bcd_digit_streamer: directed scenarios plus random traffic.
// The reference holds the count as a plain integer and the frame as a queue of pending digits.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_bcd_digit_streamer;

    localparam int ND   = 4;
    localparam int IW   = 2;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst_n, en, up_dn, load, start, out_ready;
    logic [15:0]   load_val;
    logic [15:0]   count;
    logic          tc, load_err, busy, out_valid, out_a, out_b, out_c, out_d, frame_done;
    logic [IW-1:0] out_idx;

    int errors = 0;
    int checks = 0;

    // reference state
    int         m_val  = 0;
    bit         m_tc   = 0;
    bit         m_err  = 0;
    bit         m_done = 0;
    logic [3:0] q[$];

    bcd_digit_streamer #(.NUM_DIGITS(ND), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .start(start), .out_ready(out_ready),
        .count(count), .tc(tc), .load_err(load_err), .busy(busy),
        .out_valid(out_valid), .out_idx(out_idx), .out_a(out_a), .out_b(out_b),
        .out_c(out_c), .out_d(out_d), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [28:0] obs();
        return {count, tc, load_err, busy, out_valid, out_idx, out_a, out_b, out_c, out_d, frame_done};
    endfunction

    function automatic logic [28:0] expv();
        logic          v;
        logic [IW-1:0] ix;
        logic [3:0]    dg;
        v  = (q.size() > 0);
        ix = v ? IW'(q.size() - 1) : '0;
        dg = v ? q[0] : 4'd0;
        return {to_bcd(m_val), m_tc, m_err, (v | m_done), v, ix, dg, m_done};
    endfunction

    // Advance reference by one edge using the inputs currently applied, then let the DUT take the edge.
    task automatic tick();
        int         old;
        logic [3:0] nib;
        old = m_val;
        if (!rst_n) begin
            m_val = 0; m_tc = 0; m_err = 0; m_done = 0; q.delete();
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (q.size() > 0) begin
                if (out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1;
                end
            end else if (start) begin
                for (int i = ND - 1; i >= 0; i--) q.push_back(4'((old / (10 ** i)) % 10));
            end
            m_tc  = 0;
            m_err = 0;
            if (load) begin
                m_val = 0;
                for (int i = 0; i < ND; i++) begin
                    nib = load_val[4*i +: 4];
                    if (nib > 4'd9) m_err = 1;
                    else m_val += int'(nib) * (10 ** i);
                end
            end else if (en) begin
                if (up_dn) begin
                    m_tc  = (m_val == MAXV);
                    m_val = (m_val + 1) % (MAXV + 1);
                end else begin
                    m_tc  = (m_val == 0);
                    m_val = (m_val + MAXV) % (MAXV + 1);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1; en = 0; up_dn = 1; load = 0; load_val = '0; start = 0; out_ready = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1; load_val = v;
        tick();
        load = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if (obs() !== 29'd0) begin
            errors++; $display("FAIL reset_initial got=%h exp=%h", obs(), 29'd0);
        end
        rst_n = 1;
    endtask

    task automatic test_count_carry();
        logic [15:0] exp_c[3];
        exp_c[0] = 16'h0999; exp_c[1] = 16'h1000; exp_c[2] = 16'h1001;
        do_load(16'h0998);
        en = 1; up_dn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== exp_c[i] || tc !== 1'b0) begin
                errors++; $display("FAIL carry_step%0d got=%h/%b exp=%h/0", i, count, tc, exp_c[i]);
            end
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL carry_model%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        en = 0;
    endtask

    task automatic test_wrap();
        do_load(16'h9999);
        en = 1; up_dn = 1;
        tick();
        en = 0;
        checks++;
        if (count !== 16'h0000 || tc !== 1'b1) begin
            errors++; $display("FAIL wrap_up got=%h/%b exp=0000/1", count, tc);
        end
        tick();
        checks++;
        if (tc !== 1'b0) begin
            errors++; $display("FAIL wrap_up_pulse got=%b exp=0", tc);
        end
        do_load(16'h0000);
        checks++;
        if (tc !== 1'b0) begin
            errors++; $display("FAIL load_no_tc got=%b exp=0", tc);
        end
        en = 1; up_dn = 0;
        tick();
        en = 0;
        checks++;
        if (count !== 16'h9999 || tc !== 1'b1) begin
            errors++; $display("FAIL wrap_dn got=%h/%b exp=9999/1", count, tc);
        end
        tick();
        checks++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL wrap_dn_after got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_load_err();
        do_load(16'h12A4);
        checks++;
        if (count !== 16'h1204 || load_err !== 1'b1) begin
            errors++; $display("FAIL load_err got=%h/%b exp=1204/1", count, load_err);
        end
        tick();
        checks++;
        if (load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_pulse got=%b exp=0", load_err);
        end
    endtask

    task automatic test_frame();
        logic [3:0] exp_d[4];
        exp_d[0] = 4'd4; exp_d[1] = 4'd2; exp_d[2] = 4'd7; exp_d[3] = 4'd1;
        do_load(16'h4271);
        out_ready = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(3 - i) ||
                {out_a, out_b, out_c, out_d} !== exp_d[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL frame_digit%0d got=v%b i%0d d%0d exp=v1 i%0d d%0d",
                         i, out_valid, out_idx, {out_a, out_b, out_c, out_d}, 3 - i, exp_d[i]);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL frame_done got=%b/%b exp=1/0", frame_done, out_valid);
        end
        tick();
        checks++;
        if (obs() !== expv() || busy !== 1'b0) begin
            errors++; $display("FAIL frame_idle got=%h exp=%h", obs(), expv());
        end
        out_ready = 0;
    endtask

    task automatic test_backpressure();
        bit seen;
        do_load(16'h4271);
        en = 1; up_dn = $urandom_range(0, 1); start = 1;
        tick();
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            out_ready = $urandom_range(0, 1);
            start     = $urandom_range(0, 1);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL backpressure_c%0d got=%h exp=%h", c, obs(), expv());
            end
            if (frame_done) seen = 1;
            tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL backpressure_timeout got=no_frame_done exp=frame_done");
        end
        start = 0; en = 0; out_ready = 0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_load(16'h5678);
        start = 1; out_ready = 1; en = 1;
        tick();
        start = 0;
        tick();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if (obs() !== 29'd0) begin
            errors++; $display("FAIL reset_mid_frame got=%h exp=%h", obs(), 29'd0);
        end
        idle_inputs();
        tick();
        checks++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            en        = ($urandom_range(0, 3) != 0);
            up_dn     = $urandom_range(0, 1);
            load      = ($urandom_range(0, 15) == 0);
            start     = ($urandom_range(0, 3) == 0);
            out_ready = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: v = 16'h9999;
                1: v = 16'h0000;
                2: v = 16'($urandom);
                default: v = to_bcd($urandom_range(0, MAXV));
            endcase
            load_val = v;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random_c%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_count_carry();
        test_wrap();
        test_load_err();
        test_frame();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
